// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - MIPS decode/operand-fetch stage: EX/MEM forwarding, load-use stall, ID/EX register
// Optional hazard-stall counter built only when ID_STALL_CNT_EN is defined.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_instr,
   input  logic              in_use_rs,
   input  logic              in_use_rt,
   input  logic [ADDR_W-1:0] in_wa,
   input  logic              in_we,
   output logic [ADDR_W-1:0] ra1,
   output logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic              ex_valid,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_wa,
   input  logic [DATA_W-1:0] ex_wd,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic              mem_data_ok,
   input  logic [ADDR_W-1:0] mem_wa,
   input  logic [DATA_W-1:0] mem_wd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic [DATA_W-1:0] out_opa,
   output logic [DATA_W-1:0] out_opb,
   output logic [ADDR_W-1:0] out_wa,
   output logic              out_we,
   output logic [31:0]       stall_cnt
);

   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic              rs_zero;
   logic              rt_zero;
   logic              rs_ex;
   logic              rt_ex;
   logic              rs_mem;
   logic              rt_mem;
   logic              haz_rs;
   logic              haz_rt;
   logic              hazard;
   logic              xfer;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;

   assign rs  = in_instr[21 +: ADDR_W];
   assign rt  = in_instr[16 +: ADDR_W];
   assign ra1 = rs;
   assign ra2 = rt;

   assign rs_zero = (rs == '0);
   assign rt_zero = (rt == '0);
   assign rs_ex   = ex_valid & ex_we & (ex_wa == rs);
   assign rt_ex   = ex_valid & ex_we & (ex_wa == rt);
   assign rs_mem  = mem_valid & mem_we & (mem_wa == rs);
   assign rt_mem  = mem_valid & mem_we & (mem_wa == rt);

   // A load in EX has no data yet, so it never forwards; it stalls instead when the source is used.
   always_comb begin
      opa = rd1;
      if (rs_zero)
         opa = '0;
      else if (rs_ex && !ex_is_load)
         opa = ex_wd;
      else if (rs_mem)
         opa = mem_wd;
   end

   always_comb begin
      opb = rd2;
      if (rt_zero)
         opb = '0;
      else if (rt_ex && !ex_is_load)
         opb = ex_wd;
      else if (rt_mem)
         opb = mem_wd;
   end

   assign haz_rs = in_use_rs & !rs_zero & ((rs_ex & ex_is_load) | (rs_mem & !mem_data_ok));
   assign haz_rt = in_use_rt & !rt_zero & ((rt_ex & ex_is_load) | (rt_mem & !mem_data_ok));
   assign hazard = in_valid & (haz_rs | haz_rt);

   assign in_ready = !flush & !hazard & (!out_valid | out_ready);
   assign xfer     = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
         out_opa   <= '0;
         out_opb   <= '0;
         out_wa    <= '0;
         out_we    <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (xfer)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         if (xfer) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_opa   <= opa;
            out_opb   <= opb;
            out_wa    <= in_wa;
            out_we    <= in_we;
         end
      end
   end

`ifdef ID_STALL_CNT_EN
   logic        stall_tick;
   logic [31:0] stall_q;

   assign stall_tick = hazard & !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (stall_tick)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - scoreboard bench for id_operand_stage
module tb_id_operand_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [4:0]  wa;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_use_rs;
   logic        in_use_rt;
   logic [4:0]  in_wa;
   logic        in_we;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        ex_valid;
   logic        ex_we;
   logic        ex_is_load;
   logic [4:0]  ex_wa;
   logic [31:0] ex_wd;
   logic        mem_valid;
   logic        mem_we;
   logic        mem_data_ok;
   logic [4:0]  mem_wa;
   logic [31:0] mem_wd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_opa;
   logic [31:0] out_opb;
   logic [4:0]  out_wa;
   logic        out_we;
   logic [31:0] stall_cnt;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_stall = 0;
   int          stall_step;
   bit          done = 0;

   id_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_wa(in_wa), .in_we(in_we),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_data_ok(mem_data_ok), .mem_wa(mem_wa), .mem_wd(mem_wd),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_opa(out_opa), .out_opb(out_opb), .out_wa(out_wa), .out_we(out_we),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wa, input logic we,
                        input logic [31:0] d1, input logic [31:0] d2);
      in_pc     = pc;
      in_instr  = {6'h00, rs, rt, wa, 5'd0, 6'h20};
      in_use_rs = urs;
      in_use_rt = urt;
      in_wa     = wa;
      in_we     = we;
      rd1       = d1;
      rd2       = d2;
      in_valid  = 1'b1;
   endtask

   task automatic send(input logic [31:0] eopa, input logic [31:0] eopb);
      exp_t e;
      bit   ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) begin
            e.pc = in_pc; e.instr = in_instr; e.opa = eopa; e.opb = eopb;
            e.wa = in_wa; e.we = in_we;
            sb.push_back(e);
            ok = 1;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: pc 0x%0h never accepted", in_pc);
      end
      in_valid = 1'b0;
   endtask

   task automatic clear_fwd();
      ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_wd = 0;
      mem_valid = 0; mem_we = 0; mem_data_ok = 1; mem_wa = 0; mem_wd = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
`ifdef ID_STALL_CNT_EN
      stall_step = 1;
`else
      stall_step = 0;
`endif
      reset = 1; in_valid = 0; in_pc = 0; in_instr = 0; in_use_rs = 0; in_use_rt = 0;
      in_wa = 0; in_we = 0; rd1 = 0; rd2 = 0; flush = 0; out_ready = 0;
      clear_fwd();
      fork
         begin
            exp_t e;
            while (!done) begin
               @(negedge clk);
               if (out_valid && out_ready) begin
                  if (sb.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_output: pc 0x%0h with empty scoreboard", out_pc);
                  end else begin
                     e = sb.pop_front();
                     chk("mon_pc", out_pc, e.pc);
                     chk("mon_instr", out_instr, e.instr);
                     chk("mon_opa", out_opa, e.opa);
                     chk("mon_opb", out_opb, e.opb);
                     chk("mon_wa", {27'd0, out_wa}, {27'd0, e.wa});
                     chk("mon_we", {31'd0, out_we}, {31'd0, e.we});
                  end
               end
            end
         end
         begin
            #12;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_opa", out_opa, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_stall_cnt", stall_cnt, 32'd0);
            reset = 0;
            out_ready = 1;
            cyc(1);

            // EX forwarding beats register file
            ex_valid = 1; ex_we = 1; ex_wa = 3; ex_wd = 32'h1234;
            drive(32'h100, 5'd3, 5'd4, 1, 1, 5'd10, 1, 32'hDEAD, 32'h44);
            #1;
            chk("ra1", {27'd0, ra1}, 32'd3);
            chk("ra2", {27'd0, ra2}, 32'd4);
            send(32'h1234, 32'h44);
            chk("fwd_ex_valid", {31'd0, out_valid}, 32'd1);
            chk("fwd_ex_opa", out_opa, 32'h1234);

            // EX over MEM priority, and register 0
            mem_valid = 1; mem_we = 1; mem_wa = 5; mem_wd = 32'hB;
            ex_wa = 5; ex_wd = 32'hA;
            drive(32'h104, 5'd5, 5'd0, 1, 1, 5'd11, 1, 32'h51, 32'h52);
            send(32'hA, 32'h0);
            drive(32'h108, 5'd0, 5'd5, 1, 1, 5'd12, 1, 32'h51, 32'h52);
            send(32'h0, 32'hA);
            ex_valid = 0;
            drive(32'h10C, 5'd5, 5'd6, 1, 1, 5'd13, 0, 32'h51, 32'h66);
            send(32'hB, 32'h66);
            clear_fwd();

            // load in EX to an unused source neither forwards nor stalls
            ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_wa = 9; ex_wd = 32'hBAD;
            drive(32'h110, 5'd9, 5'd0, 0, 0, 5'd0, 0, 32'h99, 32'h0);
            send(32'h99, 32'h0);

            // load-use on rt: one bubble then issue with MEM forwarding
            ex_wa = 7;
            drive(32'h114, 5'd1, 5'd7, 1, 1, 5'd14, 1, 32'h11, 32'h77);
            @(negedge clk);
            chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            exp_stall += stall_step;
            chk("lu_bubble", {31'd0, out_valid}, 32'd0);
            clear_fwd();
            mem_valid = 1; mem_we = 1; mem_wa = 7; mem_wd = 32'h700;
            send(32'h11, 32'h700);
            chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
            chk("lu_stall_cnt", stall_cnt, exp_stall);

            // MEM load data not yet returned: stall two cycles
            mem_wa = 8; mem_wd = 32'h0; mem_data_ok = 0;
            drive(32'h118, 5'd8, 5'd2, 1, 1, 5'd15, 1, 32'h1, 32'h22);
            repeat (2) begin
               @(negedge clk);
               chk("mem_wait_in_ready", {31'd0, in_ready}, 32'd0);
               @(posedge clk); #1;
               exp_stall += stall_step;
            end
            mem_data_ok = 1; mem_wd = 32'h888;
            send(32'h888, 32'h22);
            clear_fwd();
            chk("mem_wait_stall_cnt", stall_cnt, exp_stall);
            cyc(2);

            // backpressure holds payload for 3 cycles
            out_ready = 0;
            drive(32'h200, 5'd1, 5'd2, 1, 1, 5'd16, 1, 32'hA1, 32'hA2);
            send(32'hA1, 32'hA2);
            drive(32'h204, 5'd3, 5'd4, 1, 1, 5'd17, 0, 32'hB1, 32'hB2);
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
               chk("bp_hold_pc", out_pc, 32'h200);
               chk("bp_hold_opa", out_opa, 32'hA1);
               @(posedge clk); #1;
            end
            out_ready = 1;
            send(32'hB1, 32'hB2);
            chk("bp_next_pc", out_pc, 32'h204);

            // flush kills held contents and suppresses stall counting
            out_ready = 0;
            ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_wa = 7;
            drive(32'h208, 5'd7, 5'd0, 1, 0, 5'd18, 1, 32'hC0, 32'h0);
            flush = 1;
            @(negedge clk);
            chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            flush = 0; in_valid = 0;
            clear_fwd();
            chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
            chk("flush_stall_cnt", stall_cnt, exp_stall);
            if (sb.size() > 0) void'(sb.pop_front());
            out_ready = 1;
            cyc(1);

            // asynchronous reset between edges with a held instruction
            out_ready = 0;
            drive(32'h300, 5'd1, 5'd2, 1, 1, 5'd19, 1, 32'hC1, 32'hC2);
            send(32'hC1, 32'hC2);
            chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
            #2 reset = 1;
            #1;
            chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("arst_out_opa", out_opa, 32'd0);
            chk("arst_out_pc", out_pc, 32'd0);
            chk("arst_stall_cnt", stall_cnt, 32'd0);
            sb.delete();
            exp_stall = 0;
            @(negedge clk);
            reset = 0;
            out_ready = 1;
            cyc(1);

            drive(32'h400, 5'd2, 5'd3, 1, 1, 5'd20, 1, 32'hD1, 32'hD2);
            send(32'hD1, 32'hD2);
            cyc(3);
            chk("sb_drained", sb.size(), 32'd0);
            done = 1;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage of the 5-stage MIPS pipeline. Sits between the IF/ID register and the ID/EX register.
- Drives the register-file read addresses and forwards results from the EX and MEM stages.
- Detects load-use hazards and stalls.
- Holds the ID/EX pipeline register behind a valid/ready handshake.
- Writeback-stage bypass is already provided inside the register file (same-cycle write is visible on the read ports), so this block does not forward from WB.

Parameters:
- DATA_W, 32, operand/data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  32  instruction PC
- in_instr  in  32  instruction word; rs=[25:21], rt=[20:16]
- in_use_rs  in  1  instruction reads rs
- in_use_rt  in  1  instruction reads rt
- in_wa  in  5  destination register (predecoded)
- in_we  in  1  instruction writes a register
- ra1  out  5  register-file read address 1 (=rs)
- ra2  out  5  register-file read address 2 (=rt)
- rd1  in  32  register-file read data 1
- rd2  in  32  register-file read data 2
- ex_valid, ex_we, ex_is_load  in  1 each  EX-stage status
- ex_wa  in  5  EX destination register
- ex_wd  in  32  EX result
- mem_valid, mem_we, mem_data_ok  in  1 each  MEM status; mem_data_ok=0 means load data not yet returned
- mem_wa  in  5  MEM destination register
- mem_wd  in  32  MEM result
- flush  in  1  kill the stage contents (branch/exception)
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts the ID/EX contents
- out_pc, out_instr  out  32 each  registered payload
- out_opa, out_opb  out  32 each  registered forwarded operands
- out_wa  out  5  registered destination
- out_we  out  1  registered write enable
- stall_cnt  out  32  hazard-stall counter (see Optional Feature)

Behaviour:
- ra1/ra2 are combinational from in_instr, valid regardless of in_valid.
- Operand select, per source s with address a:
  - a==0 gives 0.
  - Else EX match (ex_valid & ex_we & !ex_is_load & ex_wa==a) gives ex_wd.
  - Else MEM match (mem_valid & mem_we & mem_wa==a) gives mem_wd.
  - Else rdN.
  - EX has priority over MEM.
- Hazard, evaluated when in_valid=1 and the source is used (in_use_*), a!=0:
  - (a) ex_valid & ex_we & ex_is_load & ex_wa==a;
  - (b) MEM match & !mem_data_ok.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- A transfer (in_valid & in_ready) loads the full payload into the ID/EX register; out_valid=1 on the next edge.
- out_valid clears on the next edge when:
  - the contents are consumed (out_valid & out_ready) with no new transfer; a hazard stall therefore inserts a bubble;
  - flush=1, which has priority over everything and forces out_valid=0 that cycle.
- out_valid=1 & out_ready=0: payload held stable, no new transfer.
- Latency: 1 cycle from accepted input to out_valid.
- Reset (async), all clear: out_valid=0, all out_* payload=0, stall_cnt=0. Reset mid-stall discards the held instruction.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle with in_valid & hazard & !flush. It wraps at 2^32-1 to 0.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Forward EX: instr rs=3; ex_valid=1, ex_we=1, ex_wa=3, ex_wd=0x1234, rd1=0xDEAD -> next edge out_opa=0x1234, out_valid=1.
- EX vs MEM priority: ex_wa=mem_wa=5, ex_wd=0xA, mem_wd=0xB, rs=5 -> out_opa=0xA. With rs=0 -> out_opa=0.
- Load-use: ex_is_load=1, ex_wa=rt=7, in_use_rt=1:
  - in_ready=0 and a bubble is inserted (out_valid=0) for 1 cycle;
  - the next cycle ex_valid=0, the instruction issues;
  - stall_cnt=1 with ID_STALL_CNT_EN defined.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and payload unchanged; out_ready=1 -> the next instruction loads on that edge.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 next edge, stall_cnt unchanged.
- Async reset: assert reset between clock edges -> out_valid=0 and out_opa=0 immediately, before the next clk edge.
